// File: rtl/carpark_pkg.sv
// Shared definitions for the car park entry/exit controller: FSM states,
// sensor patterns {a,b} and default capacity.
package carpark_pkg;

  localparam int MAX_CARS_DEFAULT = 15;
  localparam int COUNT_W          = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } state_t;

  // Pattern bit 1 is the outer beam (a), bit 0 the inner beam (b).
  typedef logic [1:0] pat_t;

  localparam pat_t PAT_CLEAR = 2'b00;
  localparam pat_t PAT_A     = 2'b10;
  localparam pat_t PAT_AB    = 2'b11;
  localparam pat_t PAT_B     = 2'b01;

endpackage

// File: rtl/sensor_debounce.sv
// Accepts a new sensor level only after DEBOUNCE_CYCLES consecutive samples
// that differ from the currently accepted level.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sensor,
  output logic o_sensor
);

  logic [7:0] r_cnt;
  logic       r_stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (i_sensor == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
      r_stable <= i_sensor;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_sensor = r_stable;

endmodule

// File: rtl/carpark_controller.sv
// Car park occupancy controller: two-beam direction FSM plus bounded counter.
// Optional input debounce is enabled with macro CARPARK_DEBOUNCE_EN.
module carpark_controller
  import carpark_pkg::*;
#(
  parameter int MAX_CARS        = MAX_CARS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_a,
  input  logic               sensor_b,
  output logic               inc_car,
  output logic               dec_car,
  output logic [COUNT_W-1:0] car_count,
  output logic               full,
  output logic               empty,
  output logic               seq_err
);

  if (MAX_CARS < 1 || MAX_CARS > 15) begin : g_bad_max_cars
    $error("MAX_CARS out of range 1..15");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 1..255");
  end

  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_CARS);

  logic r_a_meta, r_a_sync, r_b_meta, r_b_sync;
  logic w_a, w_b;
  pat_t w_pat;

  // NOTE: the beams are asynchronous to clk, so each passes two flops before
  // any decision is made on it; the first flop may go metastable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r_a_sync, r_a_meta} <= 2'b00;
      {r_b_sync, r_b_meta} <= 2'b00;
    end else begin
      {r_a_sync, r_a_meta} <= {r_a_meta, sensor_a};
      {r_b_sync, r_b_meta} <= {r_b_meta, sensor_b};
    end
  end

`ifdef CARPARK_DEBOUNCE_EN
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset(reset), .i_sensor(r_a_sync), .o_sensor(w_a)
  );
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset(reset), .i_sensor(r_b_sync), .o_sensor(w_b)
  );
`else
  assign w_a = r_a_sync;
  assign w_b = r_b_sync;
`endif

  assign w_pat = {w_a, w_b};

  state_t             r_state;
  pat_t               r_prev_pat;
  logic [COUNT_W-1:0] r_count;
  logic               r_inc, r_dec, r_err;

  // NOTE: pulse outputs are cleared at the top of every cycle, so a later
  // assignment in the case statement wins for exactly one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prev_pat <= PAT_CLEAR;
      r_count    <= '0;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_err      <= 1'b0;
      r_prev_pat <= w_pat;
      unique case (r_state)
        IDLE: begin
          case (w_pat)
            PAT_A:   r_state <= EN1;
            PAT_B:   r_state <= EX1;
            // Both beams blocked from idle: flag once on arrival, not per cycle.
            PAT_AB:  r_err   <= (r_prev_pat != PAT_AB);
            default: ;
          endcase
        end
        EN1: begin
          case (w_pat)
            PAT_A:     ;
            PAT_AB:    r_state <= EN2;
            PAT_CLEAR: r_state <= IDLE;
            default:   begin r_state <= IDLE; r_err <= 1'b1; end
          endcase
        end
        EN2: begin
          case (w_pat)
            PAT_AB:  ;
            PAT_B:   r_state <= EN3;
            PAT_A:   r_state <= EN1;
            default: r_state <= IDLE;
          endcase
        end
        EN3: begin
          case (w_pat)
            PAT_B:     ;
            PAT_AB:    r_state <= EN2;
            PAT_CLEAR: begin
              r_state <= IDLE;
              if (r_count == MAX_COUNT) begin
                r_err <= 1'b1;
              end else begin
                r_count <= r_count + 1'b1;
                r_inc   <= 1'b1;
              end
            end
            default:   begin r_state <= IDLE; r_err <= 1'b1; end
          endcase
        end
        EX1: begin
          case (w_pat)
            PAT_B:     ;
            PAT_AB:    r_state <= EX2;
            PAT_CLEAR: r_state <= IDLE;
            default:   begin r_state <= IDLE; r_err <= 1'b1; end
          endcase
        end
        EX2: begin
          case (w_pat)
            PAT_AB:  ;
            PAT_A:   r_state <= EX3;
            PAT_B:   r_state <= EX1;
            default: r_state <= IDLE;
          endcase
        end
        EX3: begin
          case (w_pat)
            PAT_A:     ;
            PAT_AB:    r_state <= EX2;
            PAT_CLEAR: begin
              r_state <= IDLE;
              if (r_count == '0) begin
                r_err <= 1'b1;
              end else begin
                r_count <= r_count - 1'b1;
                r_dec   <= 1'b1;
              end
            end
            default:   begin r_state <= IDLE; r_err <= 1'b1; end
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign car_count = r_count;
  assign inc_car   = r_inc;
  assign dec_car   = r_dec;
  assign seq_err   = r_err;
  assign full      = (r_count == MAX_COUNT);
  assign empty     = (r_count == '0);

endmodule
